// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state encoding, owner encoding, bus widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ADDR = 2'd1;
    localparam state_t WAIT = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an inst and a data port onto one memory port, one transaction outstanding.
// Latency: grant registered, mem_req the cycle after sampling; addr_ok/data_ok pass through from memory.
// Backpressure: requests hold until addr_ok; ARB_FAIR_EN adds a data-streak limit so inst cannot starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_data;
    logic              in_addr;
    logic              in_wait;
    logic              accept;
    logic              resp;

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(FAIR_LIMIT + 1);

    logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;
    logic             fair_hit;

    assign fair_hit   = (fair_cnt_q == CNT_W'(FAIR_LIMIT));
    assign grant_data = data_req && !(inst_req && fair_hit);

    // Counts data wins while inst is waiting; any IDLE cycle without inst_req restarts the streak.
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (state_q == IDLE) begin
            if (!inst_req || !grant_data) begin
                fair_cnt_d = '0;
            end else if (!fair_hit) begin
                fair_cnt_d = fair_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fair_cnt_q <= '0;
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end
`else
    assign grant_data = data_req;
`endif

    assign in_addr = (state_q == ADDR);
    assign in_wait = (state_q == WAIT);
    assign accept  = in_addr && mem_addr_ok;
    assign resp    = (accept && mem_data_ok) || (in_wait && mem_data_ok);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_d = ADDR;
                    if (grant_data) begin
                        owner_d = OWN_DATA;
                        wr_d    = data_wr;
                        wstrb_d = data_wstrb;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else begin
                        owner_d = OWN_INST;
                        wr_d    = 1'b0;
                        wstrb_d = '0;
                        addr_d  = inst_addr;
                        wdata_d = '0;
                    end
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = mem_data_ok ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= OWN_INST;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_req   = in_addr;
    assign mem_wr    = wr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign inst_addr_ok = accept && (owner_q == OWN_INST);
    assign data_addr_ok = accept && (owner_q == OWN_DATA);
    assign inst_data_ok = resp && (owner_q == OWN_INST);
    assign data_data_ok = resp && (owner_q == OWN_DATA);

    // Read data is a shared pass-through, forced low while reset is held.
    assign inst_rdata = resetn ? mem_rdata : '0;
    assign data_rdata = resetn ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int FAIR_LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [4:0]  ctrl;
    logic [68:0] bus;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    assign ctrl = {mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    assign bus  = {mem_wr, mem_wstrb, mem_addr, mem_wdata};

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1;
        #2 resetn = 0;
        inst_req = 1; inst_addr = 32'hFFFF_FFFF;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'hFFFF_FFFF; data_wdata = 32'hFFFF_FFFF;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL reset_ctrl got %b want 00000", ctrl); end
        nvec++; if (bus !== 69'd0) begin nerr++; $display("FAIL reset_bus got %h want 0", bus); end
        nvec++; if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
            nerr++; $display("FAIL reset_rdata got %h/%h want 0/0", inst_rdata, data_rdata);
        end
        clear_inputs();
        next_cycle();
        resetn = 1;
    endtask

    task automatic test_inst_only();
        do_reset();
        inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL inst_only_c0 got %b want 00000", ctrl); end
        next_cycle();
        @(negedge clk);
        nvec++; if (ctrl !== 5'b11000) begin nerr++; $display("FAIL inst_only_c1 got %b want 11000", ctrl); end
        nvec++; if (bus !== {1'b0, 4'h0, 32'h1C00_0000, 32'h0}) begin
            nerr++; $display("FAIL inst_only_bus got %h want fields of 1C000000 fetch", bus);
        end
        next_cycle();
        inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h0280_0000;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00100) begin nerr++; $display("FAIL inst_only_c2 got %b want 00100", ctrl); end
        nvec++; if (inst_rdata !== 32'h0280_0000) begin
            nerr++; $display("FAIL inst_only_rdata got %h want 02800000", inst_rdata);
        end
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL inst_only_c3 got %b want 00000", ctrl); end
        clear_inputs();
    endtask

    task automatic test_data_priority();
        do_reset();
        inst_req = 1; inst_addr = 32'h1C00_0004;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
        mem_addr_ok = 1;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL prio_c0 got %b want 00000", ctrl); end
        next_cycle();
        @(negedge clk);
        nvec++; if (ctrl !== 5'b10010) begin nerr++; $display("FAIL prio_c1 got %b want 10010", ctrl); end
        nvec++; if (bus !== {1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin
            nerr++; $display("FAIL prio_store_bus got %h want store 100/F/DEADBEEF", bus);
        end
        next_cycle();
        data_req = 0; mem_data_ok = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00001) begin nerr++; $display("FAIL prio_c2 got %b want 00001", ctrl); end
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL prio_c3 got %b want 00000", ctrl); end
        next_cycle();
        @(negedge clk);
        nvec++; if (ctrl !== 5'b11000) begin nerr++; $display("FAIL prio_c4 got %b want 11000", ctrl); end
        nvec++; if (bus !== {1'b0, 4'h0, 32'h1C00_0004, 32'h0}) begin
            nerr++; $display("FAIL prio_inst_bus got %h want fetch 1C000004", bus);
        end
        next_cycle();
        inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00100) begin nerr++; $display("FAIL prio_c5 got %b want 00100", ctrl); end
        clear_inputs();
    endtask

    task automatic test_addr_delay();
        logic [4:0] want;
        do_reset();
        data_req = 1; data_wr = 0; data_wstrb = 4'h0; data_addr = 32'h200; data_wdata = 32'h0;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            mem_addr_ok = (k == 3);
            want = {1'b1, 2'b00, (k == 3), 1'b0};
            @(negedge clk);
            nvec++; if (ctrl !== want) begin nerr++; $display("FAIL delay_ctrl_%0d got %b want %b", k, ctrl, want); end
            nvec++; if (bus !== {1'b0, 4'h0, 32'h200, 32'h0}) begin
                nerr++; $display("FAIL delay_bus_%0d got %h want load 200", k, bus);
            end
            next_cycle();
        end
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00001) begin nerr++; $display("FAIL delay_resp got %b want 00001", ctrl); end
        nvec++; if (data_rdata !== 32'h1234_5678) begin
            nerr++; $display("FAIL delay_rdata got %h want 12345678", data_rdata);
        end
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        do_reset();
        inst_req = 1; inst_addr = 32'h300;
        next_cycle();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b11100) begin nerr++; $display("FAIL same_cycle got %b want 11100", ctrl); end
        nvec++; if (inst_rdata !== 32'hCAFE_F00D) begin
            nerr++; $display("FAIL same_rdata got %h want CAFEF00D", inst_rdata);
        end
        next_cycle();
        // Back in IDLE: a stray response is ignored and a new request is taken at once.
        inst_req = 0; data_req = 1; data_addr = 32'h304; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL same_nowait got %b want 00000", ctrl); end
        next_cycle();
        mem_addr_ok = 1; mem_data_ok = 0;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b10010) begin nerr++; $display("FAIL same_next got %b want 10010", ctrl); end
        next_cycle();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00001) begin nerr++; $display("FAIL same_next_resp got %b want 00001", ctrl); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_req = 1; inst_addr = 32'h400; mem_addr_ok = 1;
        next_cycle();
        next_cycle();
        inst_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL mid_wait got %b want 00000", ctrl); end
        #1 resetn = 0;
        mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        nvec++; if ({ctrl, bus, inst_rdata, data_rdata} !== 138'd0) begin
            nerr++; $display("FAIL mid_in_reset got %b/%h/%h/%h want all 0", ctrl, bus, inst_rdata, data_rdata);
        end
        next_cycle();
        resetn = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            nvec++; if (ctrl !== 5'b00000) begin nerr++; $display("FAIL mid_after_%0d got %b want 00000", k, ctrl); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int ph, own;
        bit i_pend, d_pend, a_ok, d_ok, take_inst;
        logic e_wr;
        logic [3:0] e_wstrb;
        logic [31:0] e_addr, e_wdata, got_rd;
        logic [4:0] e_ctrl;
`ifdef ARB_FAIR_EN
        int cnt;
        cnt = 0;
`endif
        do_reset();
        ph = 0; own = 0; i_pend = 0; d_pend = 0;
        e_wr = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (ph == 1 && $urandom_range(7) == 0) begin
                if (own == 0 && i_pend) begin i_pend = 0; inst_addr = $urandom; end
                if (own == 1 && d_pend) begin d_pend = 0; data_addr = $urandom; data_wdata = $urandom; end
            end
            if (!i_pend && !(ph == 1 && own == 0) && $urandom_range(2) == 0) begin
                i_pend = 1; inst_addr = $urandom;
            end
            if (!d_pend && !(ph == 1 && own == 1) && $urandom_range(2) == 0) begin
                d_pend = 1; data_wr = 1'($urandom_range(1)); data_wstrb = 4'($urandom_range(15));
                data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req = i_pend; data_req = d_pend;
            mem_addr_ok = 1'($urandom_range(1));
            if (ph == 2) mem_data_ok = ($urandom_range(2) == 0);
            else if (ph == 1) mem_data_ok = mem_addr_ok && ($urandom_range(1) == 0);
            else mem_data_ok = ($urandom_range(3) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            a_ok = (ph == 1) && mem_addr_ok;
            d_ok = (a_ok && mem_data_ok) || (ph == 2 && mem_data_ok);
            e_ctrl = {ph == 1, a_ok && own == 0, d_ok && own == 0, a_ok && own == 1, d_ok && own == 1};
            nvec++; if (ctrl !== e_ctrl) begin
                nerr++; $display("FAIL rand_ctrl cyc %0d got %b want %b", cyc, ctrl, e_ctrl);
            end
            if (ph == 1) begin
                nvec++; if (bus !== {e_wr, e_wstrb, e_addr, e_wdata}) begin
                    nerr++; $display("FAIL rand_bus cyc %0d got %h want %h", cyc, bus, {e_wr, e_wstrb, e_addr, e_wdata});
                end
            end
            if (d_ok) begin
                got_rd = (own == 0) ? inst_rdata : data_rdata;
                nvec++; if (got_rd !== mem_rdata) begin
                    nerr++; $display("FAIL rand_rdata cyc %0d got %h want %h", cyc, got_rd, mem_rdata);
                end
            end
            if (ph == 0) begin
`ifdef ARB_FAIR_EN
                take_inst = i_pend && (!d_pend || cnt >= FAIR_LIMIT);
                if (!i_pend || take_inst) cnt = 0;
                else if (cnt < FAIR_LIMIT) cnt = cnt + 1;
`else
                take_inst = i_pend && !d_pend;
`endif
                if (i_pend || d_pend) begin
                    ph = 1;
                    if (take_inst) begin
                        own = 0; e_wr = 0; e_wstrb = 0; e_addr = inst_addr; e_wdata = 0;
                    end else begin
                        own = 1; e_wr = data_wr; e_wstrb = data_wstrb; e_addr = data_addr; e_wdata = data_wdata;
                    end
                end
            end else if (ph == 1) begin
                if (a_ok) begin
                    if (own == 0) i_pend = 0; else d_pend = 0;
                    ph = d_ok ? 0 : 2;
                end
            end else if (d_ok) begin
                ph = 0;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_grant_pattern();
        int grants, got_own, want_own;
        do_reset();
        inst_req = 1; inst_addr = 32'h1C00_1000;
        data_req = 1; data_wr = 0; data_addr = 32'h800;
        mem_addr_ok = 1; mem_data_ok = 1;
        grants = 0;
        for (int cyc = 0; cyc < 200 && grants < 15; cyc++) begin
            @(negedge clk);
            if (mem_req && mem_addr_ok) begin
                got_own = inst_addr_ok ? 0 : 1;
`ifdef ARB_FAIR_EN
                want_own = (grants % (FAIR_LIMIT + 1) == FAIR_LIMIT) ? 0 : 1;
`else
                want_own = 1;
`endif
                nvec++; if (got_own !== want_own) begin
                    nerr++; $display("FAIL grant_owner_%0d got %0d want %0d", grants, got_own, want_own);
                end
                grants++;
            end
            next_cycle();
        end
        nvec++; if (grants != 15) begin nerr++; $display("FAIL grant_budget got %0d want 15", grants); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_inst_only();
        test_data_priority();
        test_addr_delay();
        test_same_cycle();
        test_reset_mid();
        test_random();
        test_grant_pattern();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d vectors", nvec);
        $fatal(1);
    end

endmodule
